// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/DM memory port arbiter: FSM encoding,
// port-select constants and default parameter values.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_STREAK_MAX = 4;
    localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Team 2:1 mux (32 bits by default); selects the winning requester's
// address or store data.
module MUX_2to1
    import mem_port_arbiter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = (sel == SEL_DM) ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data memory (DM):
// DM has priority, but IF is guaranteed a grant after STREAK_MAX DM grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STREAK_MAX = DEF_STREAK_MAX,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,

    output logic              err_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              sel_o
);

    localparam int STREAK_W = $clog2(STREAK_MAX + 1);
    localparam int WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(STREAK_MAX);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    state_t              state_q;
    state_t              state_d;
    logic                grant;
    logic                if_wins;
    logic                next_sel;
    logic                timeout_hit;
    logic [STREAK_W-1:0] streak_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                timed_out_q;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    MUX_2to1 #(.W(ADDR_W)) u_addr_mux (
        .a   (if_addr_i),
        .b   (dm_addr_i),
        .sel (next_sel),
        .y   (win_addr)
    );

    MUX_2to1 #(.W(DATA_W)) u_wdata_mux (
        .a   ({DATA_W{1'b0}}),
        .b   (dm_wdata_i),
        .sel (next_sel),
        .y   (win_wdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A requester must drop its request in the cycle its ack is visible;
    // a request still held then is treated as a new transaction.
    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        timeout_hit = 1'b0;
        if_wins     = if_req_i && (!dm_req_i || (streak_q >= STREAK_CAP));
        next_sel    = if_wins ? SEL_IF : SEL_DM;
        case (state_q)
            IDLE: begin
                if (if_req_i || dm_req_i) begin
                    grant   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_o       <= SEL_IF;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_ack_o    <= 1'b0;
            if_rdata_o  <= '0;
            dm_ack_o    <= 1'b0;
            dm_rdata_o  <= '0;
            err_o       <= 1'b0;
            streak_q    <= '0;
            wait_q      <= '0;
            rdata_q     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if_ack_o   <= 1'b0;
            dm_ack_o   <= 1'b0;
            err_o      <= 1'b0;
            if_rdata_o <= '0;
            dm_rdata_o <= '0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        sel_o       <= next_sel;
                        mem_addr_o  <= win_addr;
                        mem_wdata_o <= win_wdata;
                        mem_we_o    <= (next_sel == SEL_DM) && dm_we_i;
                        mem_req_o   <= 1'b1;
                        wait_q      <= '0;
                        // Only DM grants that made IF wait count toward the streak.
                        if (next_sel == SEL_IF) begin
                            streak_q <= '0;
                        end else if (if_req_i) begin
                            streak_q <= streak_q + STREAK_W'(1);
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        mem_req_o   <= 1'b0;
                        rdata_q     <= mem_rdata_i;
                        timed_out_q <= 1'b0;
                    end else if (timeout_hit) begin
                        mem_req_o   <= 1'b0;
                        rdata_q     <= '0;
                        timed_out_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                DONE: begin
                    err_o <= timed_out_q;
                    if (sel_o == SEL_IF) begin
                        if_ack_o   <= 1'b1;
                        if_rdata_o <= rdata_q;
                    end else begin
                        dm_ack_o   <= 1'b1;
                        dm_rdata_o <= mem_we_o ? '0 : rdata_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grants and acks are queued by
// the stimulus and popped by a monitor whenever the DUT presents them.
module tb_mem_port_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int STREAK_MAX = 4;
    localparam int TIMEOUT    = 8;

    typedef struct packed {
        logic        sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } ack_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              dm_req_i = 1'b0;
    logic              dm_we_i = 1'b0;
    logic [ADDR_W-1:0] dm_addr_i = '0;
    logic [DATA_W-1:0] dm_wdata_i = '0;
    logic              dm_ack_o;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              err_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              sel_o;

    grant_t grant_q[$];
    ack_t   ack_q[$];
    int     checks = 0;
    int     failures = 0;
    int     ack_lat = 1;
    bit     never_ack = 1'b0;
    bit     stray_ack = 1'b0;
    logic   mem_req_prev = 1'b0;
    int     busy;

    mem_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STREAK_MAX(STREAK_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .sel_o(sel_o)
    );

    initial forever #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        case (addr)
            32'h100: return 32'hDEADBEEF;
            32'h104: return 32'hCAFEF00D;
            32'h108: return 32'h600DCAFE;
            32'h300: return 32'h13579BDF;
            32'h500: return 32'h0BADF00D;
            default: return 32'hA5A5A5A5;
        endcase
    endfunction

    // Memory responder: acks after ack_lat request cycles, optionally never,
    // and can throw stray acks while no request is outstanding.
    initial begin
        int resp_cnt;
        resp_cnt    = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i   = 1'b0;
            mem_rdata_i = '0;
            if (mem_req_o && !rst_i) begin
                resp_cnt++;
                if (!never_ack && resp_cnt == ack_lat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_we_o ? 32'h0 : mem_read(mem_addr_o);
                end
            end else begin
                resp_cnt = 0;
                if (stray_ack) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = 32'hFFFFFFFF;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit do_if, input logic [31:0] if_addr,
                                 input bit do_dm, input bit dm_we,
                                 input logic [31:0] dm_addr, input logic [31:0] dm_wdata);
        @(posedge clk_i);
        #1;
        if_req_i   = do_if;
        if_addr_i  = if_addr;
        dm_req_i   = do_dm;
        dm_we_i    = dm_we;
        dm_addr_i  = dm_addr;
        dm_wdata_i = dm_wdata;
    endtask

    task automatic expectGrant(input logic sel, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
        grant_q.push_back('{sel: sel, we: we, addr: addr, wdata: wdata});
    endtask

    task automatic expectAck(input logic port, input logic [31:0] rdata, input logic err);
        ack_q.push_back('{port: port, rdata: rdata, err: err});
    endtask

    // Requesters drop their request in the cycle their ack shows up; with
    // hold_dm the DM requester keeps requesting until the final wanted ack.
    task automatic runUntilAcks(input string name, input int want, input bit hold_dm,
                                input int max_cycles, output int busy_cycles);
        int seen;
        seen        = 0;
        busy_cycles = 0;
        for (int c = 0; c < max_cycles && seen < want; c++) begin
            @(posedge clk_i);
            #1;
            if (mem_req_o) busy_cycles++;
            if (if_ack_o) begin
                if_req_i = 1'b0;
                seen++;
            end
            if (dm_ack_o) begin
                if (!hold_dm || seen >= want - 1) dm_req_i = 1'b0;
                seen++;
            end
        end
        checkOutput({name, "_acks_within_budget"}, 128'(seen), 128'(want));
    endtask

    initial begin
        fork
            begin : monitor
                grant_t g;
                ack_t   a;
                ack_t   got;
                forever begin
                    @(negedge clk_i);
                    if (!rst_i) begin
                        if (mem_req_o && !mem_req_prev) begin
                            if (grant_q.size() == 0) begin
                                checks++;
                                failures++;
                                $display("[TB] FAIL unexpected_grant: got sel=%0b addr=0x%08h, required no grant",
                                         sel_o, mem_addr_o);
                            end else begin
                                g = grant_q.pop_front();
                                checkOutput("grant", 128'({sel_o, mem_we_o, mem_addr_o, mem_wdata_o}), 128'(g));
                            end
                        end
                        if (if_ack_o || dm_ack_o) begin
                            got = '{port: dm_ack_o, rdata: (dm_ack_o ? dm_rdata_o : if_rdata_o), err: err_o};
                            if (if_ack_o && dm_ack_o) begin
                                checks++;
                                failures++;
                                $display("[TB] FAIL dual_ack: got both acks, required one");
                            end else if (ack_q.size() == 0) begin
                                checks++;
                                failures++;
                                $display("[TB] FAIL unexpected_ack: got port=%0b rdata=0x%08h, required no ack",
                                         got.port, got.rdata);
                            end else begin
                                a = ack_q.pop_front();
                                checkOutput("ack", 128'(got), 128'(a));
                            end
                        end else if (err_o) begin
                            checks++;
                            failures++;
                            $display("[TB] FAIL err_without_ack: got err_o=1, required 0");
                        end
                    end
                    mem_req_prev = mem_req_o;
                end
            end
            begin : stimulus
                // Reset state
                repeat (2) @(posedge clk_i);
                @(negedge clk_i);
                checkOutput("rst_flags", 128'({if_ack_o, dm_ack_o, err_o, mem_req_o, mem_we_o, sel_o}), 128'(0));
                checkOutput("rst_if_rdata", 128'(if_rdata_o), 128'(0));
                checkOutput("rst_dm_rdata", 128'(dm_rdata_o), 128'(0));
                checkOutput("rst_mem_addr", 128'(mem_addr_o), 128'(0));
                checkOutput("rst_mem_wdata", 128'(mem_wdata_o), 128'(0));
                @(posedge clk_i);
                #1;
                rst_i = 1'b0;

                // IF only, minimum latency
                ack_lat = 1;
                applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
                expectGrant(1'b0, 1'b0, 32'h100, 32'h0);
                expectAck(1'b0, 32'hDEADBEEF, 1'b0);
                @(posedge clk_i);
                #1;
                checkOutput("lat_c1_mem_req", 128'(mem_req_o), 128'(1));
                checkOutput("lat_c1_sel", 128'(sel_o), 128'(0));
                @(posedge clk_i);
                #1;
                checkOutput("lat_c2_idle", 128'({mem_req_o, if_ack_o}), 128'(0));
                @(posedge clk_i);
                #1;
                checkOutput("lat_c3_if_ack", 128'(if_ack_o), 128'(1));
                checkOutput("lat_c3_if_rdata", 128'(if_rdata_o), 128'(32'hDEADBEEF));
                if_req_i = 1'b0;

                // Simultaneous IF and DM store: DM first, then IF
                applyStimulus(1'b1, 32'h104, 1'b1, 1'b1, 32'h200, 32'h12345678);
                expectGrant(1'b1, 1'b1, 32'h200, 32'h12345678);
                expectGrant(1'b0, 1'b0, 32'h104, 32'h0);
                expectAck(1'b1, 32'h0, 1'b0);
                expectAck(1'b0, 32'hCAFEF00D, 1'b0);
                runUntilAcks("simul", 2, 1'b0, 30, busy);

                // DM held with IF pending: 4 DM, 1 IF, DM resumes
                applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 32'h500, 32'h0);
                for (int i = 0; i < 4; i++) begin
                    expectGrant(1'b1, 1'b0, 32'h500, 32'h0);
                    expectAck(1'b1, 32'h0BADF00D, 1'b0);
                end
                expectGrant(1'b0, 1'b0, 32'h104, 32'h0);
                expectAck(1'b0, 32'hCAFEF00D, 1'b0);
                expectGrant(1'b1, 1'b0, 32'h500, 32'h0);
                expectAck(1'b1, 32'h0BADF00D, 1'b0);
                runUntilAcks("streak", 6, 1'b1, 60, busy);

                // DM drops its request mid-transaction; it still completes
                ack_lat = 3;
                applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h108, 32'h0);
                expectGrant(1'b1, 1'b0, 32'h108, 32'h0);
                expectAck(1'b1, 32'h600DCAFE, 1'b0);
                @(posedge clk_i);
                #1;
                dm_req_i = 1'b0;
                runUntilAcks("drop", 1, 1'b0, 20, busy);

                // Timeout: memory never acks
                never_ack = 1'b1;
                applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0);
                expectGrant(1'b1, 1'b0, 32'h400, 32'h0);
                expectAck(1'b1, 32'h0, 1'b1);
                runUntilAcks("timeout", 1, 1'b0, 30, busy);
                checkOutput("timeout_busy_cycles", 128'(busy), 128'(TIMEOUT));
                @(posedge clk_i);
                #1;
                checkOutput("timeout_back_idle", 128'({mem_req_o, err_o, dm_ack_o}), 128'(0));
                never_ack = 1'b0;

                // Stray memory acks while idle are ignored
                stray_ack = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk_i);
                    #1;
                    checkOutput("stray_ignored", 128'({mem_req_o, if_ack_o, dm_ack_o, err_o}), 128'(0));
                end
                stray_ack = 1'b0;

                // Reset in the second BUSY cycle abandons the transaction
                ack_lat = 5;
                applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0);
                expectGrant(1'b0, 1'b0, 32'h300, 32'h0);
                @(posedge clk_i);
                #1;
                @(posedge clk_i);
                #2;
                rst_i    = 1'b1;
                if_req_i = 1'b0;
                #1;
                checkOutput("midrst_flags", 128'({mem_req_o, if_ack_o, dm_ack_o, err_o, sel_o}), 128'(0));
                checkOutput("midrst_mem_addr", 128'(mem_addr_o), 128'(0));
                @(posedge clk_i);
                #1;
                rst_i = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(posedge clk_i);
                    #1;
                    checkOutput("midrst_no_ack", 128'({if_ack_o, dm_ack_o, err_o, mem_req_o}), 128'(0));
                end
                ack_lat = 1;
                applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
                expectGrant(1'b0, 1'b0, 32'h100, 32'h0);
                expectAck(1'b0, 32'hDEADBEEF, 1'b0);
                runUntilAcks("after_rst", 1, 1'b0, 20, busy);
                checkOutput("after_rst_busy_cycles", 128'(busy), 128'(1));

                repeat (3) @(posedge clk_i);
                checkOutput("grant_queue_drained", 128'(grant_q.size()), 128'(0));
                checkOutput("ack_queue_drained", 128'(ack_q.size()), 128'(0));
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory data width.
REQ-002 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-003 SHALL have parameter STREAK_MAX, default 4, the maximum number of consecutive DM grants while IF is pending.
REQ-004 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for mem_ack_i.
REQ-005 SHALL use one clock, clk_i, and sample all inputs and register all outputs on its rising edge.
REQ-006 SHALL reset on rst_i, an asynchronous, active-high input.
REQ-007 if_req_i  in  1: instruction-fetch read request; held until if_ack_o.
REQ-008 if_addr_i  in  ADDR_W: fetch address.
REQ-009 if_ack_o  out  1: one-cycle completion pulse for IF.
REQ-010 if_rdata_o  out  DATA_W: fetch data, valid while if_ack_o=1.
REQ-011 dm_req_i  in  1: data-memory request; held until dm_ack_o.
REQ-012 dm_we_i  in  1: 1=store, 0=load.
REQ-013 dm_addr_i  in  ADDR_W, and dm_wdata_i  in  DATA_W: data-memory address and store data.
REQ-014 dm_ack_o  out  1, and dm_rdata_o  out  DATA_W: DM completion pulse and load data.
REQ-015 err_o  out  1: pulses together with the ack when a transaction times out.
REQ-016 mem_req_o  out  1, mem_we_o  out  1, mem_addr_o  out  ADDR_W, mem_wdata_o  out  DATA_W: shared memory port.
REQ-017 mem_ack_i  in  1, and mem_rdata_i  in  DATA_W: memory completion and read data.
REQ-018 sel_o  out  1: owner of the port (0=IF, 1=DM); drives the datapath address/data select.

Function
REQ-019 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-020 In IDLE with any request pending, SHALL pick a winner, latch its address, we and wdata, set sel_o, and enter BUSY next cycle.
REQ-021 Arbitration SHALL give DM priority, except that IF SHALL win once the streak reaches STREAK_MAX with if_req_i=1.
REQ-022 The streak counter SHALL increment on each DM grant made while if_req_i=1, and clear on any IF grant.
REQ-023 In BUSY, SHALL hold mem_req_o=1 with stable latched outputs until mem_ack_i=1, then enter DONE.
REQ-024 In DONE, SHALL pulse the winner's ack for exactly one cycle with rdata captured from mem_rdata_i at the ack edge, deassert mem_req_o, and return to IDLE.
REQ-025 Minimum latency SHALL be: request at cycle 0, mem_req_o at cycle 1, ack_o at cycle 3 if mem_ack_i=1 at cycle 1.
REQ-026 SHALL force mem_we_o=0 for IF transactions, and rdata_o SHALL be don't-care for stores (zero preferred).
REQ-027 A requester dropping its request mid-transaction SHALL NOT abort it; the transaction completes and the ack still pulses.
REQ-028 When both requests arrive in the same IDLE cycle, the streak rule SHALL decide the winner, and the loser SHALL wait with no request lost.
REQ-029 A wait counter SHALL count BUSY cycles; when it reaches TIMEOUT without mem_ack_i, SHALL enter DONE with rdata=0 and err_o=1.
REQ-030 mem_ack_i outside BUSY SHALL be ignored.
REQ-031 The back-to-back gap SHALL be one IDLE cycle between transactions (no grant in DONE).

Reset
REQ-032 On rst_i=1 (asynchronous), SHALL set state=IDLE, all outputs 0, the streak counter 0, the wait counter 0, and the latches 0.
REQ-033 Reset mid-BUSY SHALL abandon the transaction with no ack or err; requesters reissue after reset.

Structure
REQ-034 A shared package SHALL hold the state encoding, the SEL_IF/SEL_DM constants and the default parameter values.
REQ-035 Winner address and wdata selection SHALL use two instances of the team's 32-bit 2:1 mux MUX_2to1, driven by the next-sel signal; no other sub-module.

Verification
REQ-036 IF only: addr 0x100, mem_ack_i at the first BUSY cycle, rdata 0xDEADBEEF -> if_ack_o at cycle 3, if_rdata_o=0xDEADBEEF, sel_o=0.
REQ-037 Simultaneous IF and DM (store 0x200 <- 0x12345678) -> DM granted first with mem_we_o=1, then IF; two acks, in that order.
REQ-038 DM held continuously with IF pending, STREAK_MAX=4 -> 4 DM grants, then 1 IF grant, then DM resumes.
REQ-039 mem_ack_i never asserted, TIMEOUT=8 -> ack and err_o pulse together after 8 BUSY cycles, rdata=0, FSM back to IDLE.
REQ-040 rst_i asserted in the 2nd BUSY cycle -> outputs 0 immediately, no ack; a fresh IF request afterwards completes normally.
